// File: rtl/parity_acc_pkg.sv
// Shared types and helpers for the streaming parity / NAND frame accumulator.
package parity_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Bits needed to hold a word count from 0 up to max_words inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_words);
      return $clog2(max_words + 1);
   endfunction

endpackage

// File: rtl/word_reduce.sv
// Per-word reductions: XOR parity and AND (all-ones) of a single input word.
module word_reduce #(
   parameter int unsigned WIDTH = 3
) (
   input  logic [WIDTH-1:0] i_data,
   output logic             o_wx,
   output logic             o_wa
);

   assign o_wx = ^i_data;
   assign o_wa = &i_data;

endmodule

// File: rtl/parity_nand_accumulator.sv
// Frame-level XOR-parity and NAND-reduction accumulator with valid/ready on
// both the word input and the frame-result output.
module parity_nand_accumulator
   import parity_acc_pkg::*;
#(
   parameter int unsigned WIDTH      = 3,
   parameter int unsigned MAX_WORDS  = 16,
   parameter bit          ODD_PARITY = 1'b0,
   localparam int unsigned CW        = cnt_width(MAX_WORDS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_parity,
   output logic             out_nand,
   output logic [CW-1:0]    out_count,
   output logic             out_truncated
);

   state_t          r_state;
   logic            r_par_acc;
   logic            r_and_acc;
   logic [CW-1:0]   r_cnt;
   logic            r_in_ready;
   logic            r_out_valid;
   logic            r_out_parity;
   logic            r_out_nand;
   logic [CW-1:0]   r_out_count;
   logic            r_out_truncated;

   logic            w_wx;
   logic            w_wa;
   logic            w_accept;
   logic [CW-1:0]   w_cnt_next;
   logic            w_par_next;
   logic            w_and_next;
   logic            w_hit_max;
   logic            w_close;

   word_reduce #(.WIDTH(WIDTH)) u_word_reduce (
      .i_data (in_data),
      .o_wx   (w_wx),
      .o_wa   (w_wa)
   );

   // Running values including the word currently offered.
   assign w_accept   = in_valid & r_in_ready;
   assign w_cnt_next = r_cnt + CW'(1);
   assign w_par_next = r_par_acc ^ w_wx;
   assign w_and_next = r_and_acc & w_wa;
   assign w_hit_max  = (w_cnt_next == CW'(MAX_WORDS));
   assign w_close    = in_last | w_hit_max;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_par_acc       <= 1'b0;
         r_and_acc       <= 1'b1;
         r_cnt           <= '0;
         r_in_ready      <= 1'b1;
         r_out_valid     <= 1'b0;
         r_out_parity    <= 1'b0;
         r_out_nand      <= 1'b0;
         r_out_count     <= '0;
         r_out_truncated <= 1'b0;
      end else begin
         case (r_state)
            IDLE, ACCUM: begin
               if (w_accept) begin
                  if (w_close) begin
                     // Closing word: publish the frame result and stall input.
                     r_state         <= HOLD;
                     r_in_ready      <= 1'b0;
                     r_out_valid     <= 1'b1;
                     r_out_parity    <= w_par_next ^ ODD_PARITY;
                     r_out_nand      <= ~w_and_next;
                     r_out_count     <= w_cnt_next;
                     r_out_truncated <= ~in_last;
                  end else begin
                     r_state   <= ACCUM;
                     r_par_acc <= w_par_next;
                     r_and_acc <= w_and_next;
                     r_cnt     <= w_cnt_next;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_par_acc   <= 1'b0;
                  r_and_acc   <= 1'b1;
                  r_cnt       <= '0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_par_acc   <= 1'b0;
               r_and_acc   <= 1'b1;
               r_cnt       <= '0;
            end
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign out_valid     = r_out_valid;
   assign out_parity    = r_out_parity;
   assign out_nand      = r_out_nand;
   assign out_count     = r_out_count;
   assign out_truncated = r_out_truncated;

endmodule

// File: tb/tb_parity_nand_accumulator.sv
// Scoreboard bench: two instances (even / odd parity, MAX_WORDS=4) share stimulus.
module tb_parity_nand_accumulator;

   localparam int unsigned WIDTH = 3;
   localparam int unsigned MAXW  = 4;
   localparam int unsigned CW    = $clog2(MAXW + 1);

   typedef struct packed {
      logic          par;
      logic          nnd;
      logic [CW-1:0] cnt;
      logic          trunc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_ready;

   logic             in_ready0, out_valid0, out_parity0, out_nand0, out_trunc0;
   logic [CW-1:0]    out_count0;
   logic             in_ready1, out_valid1, out_parity1, out_nand1, out_trunc1;
   logic [CW-1:0]    out_count1;

   exp_t q0[$];
   exp_t q1[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   parity_nand_accumulator #(.WIDTH(WIDTH), .MAX_WORDS(MAXW), .ODD_PARITY(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
      .out_ready(out_ready), .out_parity(out_parity0), .out_nand(out_nand0),
      .out_count(out_count0), .out_truncated(out_trunc0)
   );

   parity_nand_accumulator #(.WIDTH(WIDTH), .MAX_WORDS(MAXW), .ODD_PARITY(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
      .out_ready(out_ready), .out_parity(out_parity1), .out_nand(out_nand1),
      .out_count(out_count1), .out_truncated(out_trunc1)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_frame(input logic par, input logic nnd, input int cnt, input logic trunc);
      exp_t e;
      e.par = par; e.nnd = nnd; e.cnt = CW'(cnt); e.trunc = trunc;
      q0.push_back(e);
      e.par = ~par;
      q1.push_back(e);
   endtask

   // Offer one word until accepted; called and returns at posedge+1.
   task automatic send(input logic [WIDTH-1:0] d, input logic last);
      logic ok;
      int   tries;
      in_valid = 1'b1; in_data = d; in_last = last;
      ok = 1'b0; tries = 0;
      while (!ok && tries < 50) begin
         @(negedge clk);
         ok = in_ready0;
         @(posedge clk); #1;
         tries++;
      end
      if (!ok) chk("send_timeout", 8'd0, 8'd1);
      in_valid = 1'b0; in_data = '0; in_last = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
   endtask

   // Monitors: compare at every result handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid0 && out_ready) begin
         if (q0.size() == 0) chk("dut0_unexpected_result", 8'd1, 8'd0);
         else begin
            exp_t e, a;
            e = q0.pop_front();
            a.par = out_parity0; a.nnd = out_nand0; a.cnt = out_count0; a.trunc = out_trunc0;
            chk("dut0_result", 8'(a), 8'(e));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid1 && out_ready) begin
         if (q1.size() == 0) chk("dut1_unexpected_result", 8'd1, 8'd0);
         else begin
            exp_t e, a;
            e = q1.pop_front();
            a.par = out_parity1; a.nnd = out_nand1; a.cnt = out_count1; a.trunc = out_trunc1;
            chk("dut1_result", 8'(a), 8'(e));
         end
      end
   end

   initial begin
      int waited;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

      // Reset values, during reset and on the first cycle after it.
      @(negedge clk);
      chk("rst_out_valid", 8'(out_valid0), 8'd0);
      chk("rst_outputs", {3'b0, out_parity0, out_nand0, out_count0}, 8'd0);
      chk("rst_trunc", 8'(out_trunc0), 8'd0);
      chk("rst_in_ready", 8'(in_ready0), 8'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_out_valid", 8'(out_valid0), 8'd0);
      chk("post_rst_in_ready", 8'(in_ready0), 8'd1);
      idle_cycle();

      // Single all-ones word with last: one-cycle latency, then back to idle.
      expect_frame(1'b1, 1'b0, 1, 1'b0);
      send(3'b111, 1'b1);
      @(negedge clk);
      chk("single_latency_valid", 8'(out_valid0), 8'd1);
      @(negedge clk);
      chk("single_after_valid", 8'(out_valid0), 8'd0);
      chk("single_after_ready", 8'(in_ready0), 8'd1);
      idle_cycle();

      // Three-word frame with mixed bits.
      expect_frame(1'b0, 1'b1, 3, 1'b0);
      send(3'b011, 1'b0);
      send(3'b110, 1'b0);
      send(3'b101, 1'b1);
      repeat (3) idle_cycle();

      // in_last together with the MAX_WORDS-th word is not a truncation.
      expect_frame(1'b1, 1'b1, 4, 1'b0);
      send(3'b101, 1'b0);
      send(3'b101, 1'b0);
      send(3'b101, 1'b0);
      send(3'b010, 1'b1);
      repeat (3) idle_cycle();

      // Truncation at MAX_WORDS with backpressure held for five cycles.
      expect_frame(1'b0, 1'b0, 4, 1'b1);
      out_ready = 1'b0;
      repeat (4) send(3'b111, 1'b0);
      in_valid = 1'b1; in_data = 3'b111; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 8'(out_valid0), 8'd1);
         chk("bp_in_ready", 8'(in_ready0), 8'd0);
         chk("bp_held_result", {3'b0, out_parity0, out_nand0, out_count0}, {3'b0, 1'b0, 1'b0, 3'd4});
         chk("bp_held_trunc", 8'(out_trunc0), 8'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_valid", 8'(out_valid0), 8'd0);
      chk("bp_release_ready", 8'(in_ready0), 8'd1);
      idle_cycle();

      // Fifth all-ones word opens a new frame, closed by a zero word.
      expect_frame(1'b1, 1'b1, 2, 1'b0);
      send(3'b111, 1'b0);
      send(3'b000, 1'b1);
      repeat (3) idle_cycle();

      // Gapped input: garbage on idle cycles must not be sampled.
      expect_frame(1'b1, 1'b1, 3, 1'b0);
      in_valid = 1'b1; in_data = 3'b001; in_last = 1'b0; idle_cycle();
      in_valid = 1'b0; in_data = 3'b111; in_last = 1'b1; idle_cycle();
      idle_cycle();
      in_valid = 1'b1; in_data = 3'b001; in_last = 1'b0; idle_cycle();
      in_valid = 1'b1; in_data = 3'b001; in_last = 1'b1; idle_cycle();
      in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      repeat (3) idle_cycle();

      // Reset mid-frame discards the partial frame.
      send(3'b111, 1'b0);
      send(3'b111, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", 8'(out_valid0), 8'd0);
      chk("midrst_in_ready", 8'(in_ready0), 8'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      expect_frame(1'b0, 1'b1, 1, 1'b0);
      send(3'b000, 1'b1);

      waited = 0;
      while ((q0.size() != 0 || q1.size() != 0) && waited < 20) begin
         idle_cycle();
         waited++;
      end
      if (q0.size() != 0) chk("dut0_pending_results", 8'(q0.size()), 8'd0);
      if (q1.size() != 0) chk("dut1_pending_results", 8'(q1.size()), 8'd0);
      repeat (2) idle_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
